// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller sitting beside the ID stage.
// Tracks the destination info of the two instructions ahead of ID (EX and MEM
// shadow slots) and resolves data-memory wait states, taken branches/jumps and
// load-use hazards. It also selects operand forwarding for the ID instruction.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   id_valid                     ID holds a real instruction
//   id_rs, id_rt, id_uses_rt     ID source registers; rt only matters when read
//   id_memread, id_regwrite      decoded control of the ID instruction
//   id_dst                       ID destination register
//   ex_taken                     EX resolved a taken BEQ or a JAL
//   dmem_req, dmem_ready         MEM-stage data memory handshake
//   stall                        decoder forces its control word to zero
//   pc_hold, ifid_hold           PC and IF/ID keep their values
//   flush_ifid, flush_idex       IF/ID and ID/EX load a bubble
//   fwd_a, fwd_b                 00 regfile, 01 EX result, 10 MEM result
//   mem_timeout                  sticky: memory wait lasted MEM_TIMEOUT cycles
//
// All outputs except mem_timeout are combinational (Mealy) so the pipeline can
// react in the same cycle a hazard is seen.
module hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_memread,
  input  logic             id_regwrite,
  input  logic [REG_W-1:0] id_dst,
  input  logic             ex_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_EX  = 2'b01;
  localparam logic [1:0]  FWD_MEM = 2'b10;

  typedef struct packed {
    logic             memread;
    logic             regwrite;
    logic [REG_W-1:0] dst;
  } slot_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic frozen;
  logic load_use;

  // Forward select for one source operand; EX beats MEM, r0 never matches.
  // A load in EX cannot forward yet, that case is covered by the load-use stall.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input slot_t            ex_s,
                                         input slot_t            mem_s);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_s.regwrite && !ex_s.memread && (ex_s.dst != '0) && (ex_s.dst == src)) begin
      sel = FWD_EX;
    end else if (mem_s.regwrite && (mem_s.dst != '0) && (mem_s.dst == src)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

  // State, shadow slots, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, shadow advance and hazard outputs.
  always_comb begin
    state_d    = state_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    stall      = 1'b0;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;

    // A miss in RUN freezes the very cycle it is seen, not one cycle later.
    frozen   = (state_q == ST_MEM_WAIT) || (dmem_req && !dmem_ready);
    load_use = id_valid && ex_q.memread && (ex_q.dst != '0) &&
               ((ex_q.dst == id_rs) || (id_uses_rt && (ex_q.dst == id_rt)));

    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (dmem_req && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt_q != CNT_W'(MEM_TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
          timeout_d = 1'b1;
        end
        // The ready cycle itself is still frozen; RUN resumes on the next one.
        if (dmem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (frozen) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
    end else if (ex_taken) begin
      // Squash the wrong-path instructions in IF and ID.
      stall      = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      ex_d       = '0;
      mem_d      = ex_q;
    end else if (load_use) begin
      // Hold ID one cycle and push a bubble into EX.
      stall      = 1'b1;
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      flush_idex = 1'b1;
      ex_d       = '0;
      mem_d      = ex_q;
    end else begin
      mem_d = ex_q;
      if (id_valid) begin
        ex_d.memread  = id_memread;
        ex_d.regwrite = id_regwrite;
        ex_d.dst      = id_dst;
      end else begin
        ex_d = '0;
      end
    end

    fwd_a = fwd_sel(id_rs, ex_q, mem_q);
    fwd_b = fwd_sel(id_rt, ex_q, mem_q);

    // Quiet outputs while reset is asserted so nothing acts on stale state.
    if (rst) begin
      stall      = 1'b0;
      pc_hold    = 1'b0;
      ifid_hold  = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
    end
  end

  assign mem_timeout = timeout_q;

endmodule
